// File: rtl/s2p_demux_8_if.sv
`default_nettype none
// ============================================================================
//  Module      : s2p_demux_8_if
//  Description : Serial-link receive bundle for s2p_demux_8.
//                master : serial source / byte consumer (drives EN, SIN, SYNC)
//                slave  : the deserializer (drives D, VALID, ERR, BIT_CNT, BUSY)
//  Signals     : EN       bit enable
//                SIN      serial data bit
//                SYNC     frame start, marks bit 0
//                D[7:0]   last complete received byte
//                VALID    1-cycle pulse, D updated
//                ERR      1-cycle pulse, frame aborted by mid-frame SYNC
//                BIT_CNT  index of next bit to be received
//                BUSY     frame in progress
//  Revision    : 1.0  initial release
// ============================================================================
interface s2p_demux_8_if;
  logic       EN;
  logic       SIN;
  logic       SYNC;
  logic [7:0] D;
  logic       VALID;
  logic       ERR;
  logic [2:0] BIT_CNT;
  logic       BUSY;

  modport master (
    output EN, SIN, SYNC,
    input  D, VALID, ERR, BIT_CNT, BUSY
  );

  modport slave (
    input  EN, SIN, SYNC,
    output D, VALID, ERR, BIT_CNT, BUSY
  );
endinterface
`default_nettype wire

// File: rtl/s2p_demux_8.sv
`default_nettype none
// ============================================================================
//  Module      : s2p_demux_8
//  Description : 8-bit serial-to-parallel receiver. One serial bit is sampled
//                per enabled clock and steered into its byte slot through a
//                one-hot decode of BIT_CNT; the assembled byte is presented on
//                D together with a single-cycle VALID strobe.
//  Ports       : CP   clock, rising edge
//                CR   synchronous active-high reset
//                bus  s2p_demux_8_if.slave (EN/SIN/SYNC in,
//                     D/VALID/ERR/BIT_CNT/BUSY out)
//  Parameters  : LSB_FIRST     1: first bit -> D[0], 0: first bit -> D[7]
//                SYNC_REQUIRED 1: every frame needs SYNC, 0: free-running
//  Revision    : 1.0  initial release
// ============================================================================
module s2p_demux_8 #(
  parameter bit LSB_FIRST     = 1'b1,
  parameter bit SYNC_REQUIRED = 1'b1
) (
  input  logic         CP,
  input  logic         CR,
  s2p_demux_8_if.slave bus
);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_shift = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_next_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_d;
  logic       r_valid;
  logic       r_err;
  logic       w_busy;

  logic [7:0] w_onehot;
  logic [7:0] w_slot_mask;
  logic [7:0] w_first_mask;
  logic [7:0] w_merged;
  logic       w_in_shift;
  logic       w_frame_start;
  logic       w_abort;
  logic       w_accept;

  // Bit-slot decode: BIT_CNT selects one slot; MSB-first mirrors the decode.
  assign w_onehot = 8'b0000_0001 << r_bit_cnt;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_slot_mask  = w_onehot;
      assign w_first_mask = 8'h01;
    end else begin : g_msb_first
      for (genvar i = 0; i < 8; i++) begin : g_rev
        assign w_slot_mask[i] = w_onehot[7-i];
      end
      assign w_first_mask = 8'h80;
    end
  endgenerate

  assign w_in_shift = (r_state == c_st_shift);

  // Any enabled SYNC starts a fresh frame; inside a partly received frame it
  // is an abort. A SYNC at BIT_CNT=0 in free-run mode is a clean restart.
  assign w_frame_start = bus.EN & bus.SYNC;
  assign w_abort       = bus.EN & bus.SYNC & w_in_shift & (r_bit_cnt != 3'd0);
  assign w_accept      = bus.EN & w_in_shift;

  // Shift register with the current bit merged into its slot; on the last
  // bit this is the completed byte.
  assign w_merged = (r_shift & ~w_slot_mask) | (w_slot_mask & {8{bus.SIN}});

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CP) begin
    if (CR) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (bus.EN && bus.SYNC) begin
          w_next_state = c_st_shift;
        end
      end
      c_st_shift: begin
        if (bus.EN && !bus.SYNC && (r_bit_cnt == 3'd7) && SYNC_REQUIRED) begin
          w_next_state = c_st_idle;
        end
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_busy = 1'b0;
    if (r_state == c_st_shift) begin
      w_busy = 1'b1;
    end
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge CP) begin
    if (CR) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_d       <= 8'h00;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= w_abort;
      if (w_frame_start) begin
        // Partial byte (if any) is discarded; SIN becomes bit 0.
        r_shift   <= w_first_mask & {8{bus.SIN}};
        r_bit_cnt <= 3'd1;
      end else if (w_accept) begin
        r_shift <= w_merged;
        if (r_bit_cnt == 3'd7) begin
          r_d       <= w_merged;
          r_valid   <= 1'b1;
          r_bit_cnt <= 3'd0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

  assign bus.D       = r_d;
  assign bus.VALID   = r_valid;
  assign bus.ERR     = r_err;
  assign bus.BIT_CNT = r_bit_cnt;
  assign bus.BUSY    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_s2p_demux_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s2p_demux_8
//  Description : Testbench for s2p_demux_8. Three instances share one input
//                stream: (LSB_FIRST,SYNC_REQUIRED) = (1,1), (0,1), (1,0).
//                A frame-level reference model predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_s2p_demux_8;

  logic cp = 1'b0;
  logic cr;
  logic en;
  logic sin;
  logic sync;

  always #5 cp = ~cp;

  s2p_demux_8_if if_a ();
  s2p_demux_8_if if_b ();
  s2p_demux_8_if if_c ();

  assign if_a.EN = en;  assign if_a.SIN = sin;  assign if_a.SYNC = sync;
  assign if_b.EN = en;  assign if_b.SIN = sin;  assign if_b.SYNC = sync;
  assign if_c.EN = en;  assign if_c.SIN = sin;  assign if_c.SYNC = sync;

  s2p_demux_8 #(.LSB_FIRST(1'b1), .SYNC_REQUIRED(1'b1)) u_dut_a (.CP(cp), .CR(cr), .bus(if_a));
  s2p_demux_8 #(.LSB_FIRST(1'b0), .SYNC_REQUIRED(1'b1)) u_dut_b (.CP(cp), .CR(cr), .bus(if_b));
  s2p_demux_8 #(.LSB_FIRST(1'b1), .SYNC_REQUIRED(1'b0)) u_dut_c (.CP(cp), .CR(cr), .bus(if_c));

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- Reference model (one per instance) ----------------
  bit       m_lsb  [3] = '{1'b1, 1'b0, 1'b1};
  bit       m_sreq [3] = '{1'b1, 1'b1, 1'b0};
  bit       m_bits [3][8];
  int       m_cnt  [3];
  bit       m_busy [3];
  bit [7:0] m_d    [3];
  bit       m_valid[3];
  bit       m_err  [3];

  function automatic bit [7:0] assemble(int k);
    int v = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_bits[k][i]) v += m_lsb[k] ? (1 << i) : (1 << (7 - i));
    end
    return v[7:0];
  endfunction

  function automatic void model_edge(bit c, bit e, bit s, bit y);
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0;
      m_err[k]   = 1'b0;
      if (c) begin
        m_busy[k] = 1'b0; m_cnt[k] = 0; m_d[k] = 8'h00;
      end else if (e) begin
        if (y) begin
          if (m_busy[k] && m_cnt[k] != 0) m_err[k] = 1'b1;
          m_busy[k]    = 1'b1;
          m_bits[k][0] = s;
          m_cnt[k]     = 1;
        end else if (m_busy[k]) begin
          m_bits[k][m_cnt[k]] = s;
          m_cnt[k]++;
          if (m_cnt[k] == 8) begin
            m_d[k]     = assemble(k);
            m_valid[k] = 1'b1;
            m_cnt[k]   = 0;
            if (m_sreq[k]) m_busy[k] = 1'b0;
          end
        end
      end
    end
  endfunction

  function automatic bit [13:0] expv(int k);
    bit [2:0] c3 = 3'(m_cnt[k]);
    return {m_d[k], m_valid[k], m_err[k], c3, m_busy[k]};
  endfunction

  function automatic logic [13:0] obsv(int k);
    case (k)
      0:       return {if_a.D, if_a.VALID, if_a.ERR, if_a.BIT_CNT, if_a.BUSY};
      1:       return {if_b.D, if_b.VALID, if_b.ERR, if_b.BIT_CNT, if_b.BUSY};
      default: return {if_c.D, if_c.VALID, if_c.ERR, if_c.BIT_CNT, if_c.BUSY};
    endcase
  endfunction

  // One clock: drive inputs, advance model at the edge, settle past the edge.
  task automatic step(bit c, bit e, bit s, bit y);
    cr = c; en = e; sin = s; sync = y;
    @(posedge cp);
    model_edge(c, e, s, y);
    #1;
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obsv(k) !== 14'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d got %h want %h", k, obsv(k), 14'h0);
      end
    end
    step(0, 0, 0, 0);
  endtask

  // Stream 0,1,0,1,... : AA LSB-first, 55 MSB-first.
  task automatic test_frame(int gap_after, int gap_len);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, i[0], i == 0);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          step(0, 0, 1, 1);
          n_vec++;
          if (if_a.BIT_CNT !== 3'd4 || if_a.VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_hold bit_cnt got %0d want 4 valid got %b", if_a.BIT_CNT, if_a.VALID);
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obsv(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL frame dut%0d bit%0d got %h want %h", k, i, obsv(k), expv(k));
        end
      end
    end
    n_vec++;
    if (if_a.D !== 8'hAA || if_a.VALID !== 1'b1 || if_a.BUSY !== 1'b0 || if_a.BIT_CNT !== 3'd0) begin
      n_fail++;
      $display("FAIL frame_aa got D=%h V=%b B=%b C=%0d want AA 1 0 0", if_a.D, if_a.VALID, if_a.BUSY, if_a.BIT_CNT);
    end
    n_vec++;
    if (if_b.D !== 8'h55 || if_b.VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_msb got D=%h V=%b want 55 1", if_b.D, if_b.VALID);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if (if_a.VALID !== 1'b0 || if_a.D !== 8'hAA) begin
      n_fail++;
      $display("FAIL valid_pulse got V=%b D=%h want 0 AA", if_a.VALID, if_a.D);
    end
  endtask

  task automatic test_abort();
    bit [7:0] f = 8'h0F;
    for (int i = 0; i < 5; i++) step(0, 1, 1, i == 0);
    step(0, 1, f[0], 1);  // SYNC at bit 5 aborts, starts new frame
    n_vec++;
    if (if_a.ERR !== 1'b1 || if_a.D !== 8'hAA || if_a.BIT_CNT !== 3'd1 || if_a.VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_err got E=%b D=%h C=%0d want 1 AA 1", if_a.ERR, if_a.D, if_a.BIT_CNT);
    end
    for (int i = 1; i < 8; i++) begin
      step(0, 1, f[i], 0);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obsv(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL abort dut%0d bit%0d got %h want %h", k, i, obsv(k), expv(k));
        end
      end
    end
    n_vec++;
    if (if_a.D !== 8'h0F || if_a.VALID !== 1'b1 || if_a.ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_frame got D=%h V=%b want 0F 1", if_a.D, if_a.VALID);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 1, i == 0);
    step(1, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obsv(k) !== 14'h0) begin
        n_fail++;
        $display("FAIL mid_reset dut%0d got %h want %h", k, obsv(k), 14'h0);
      end
    end
  endtask

  // Free-run: one SYNC, then AA and 33 back to back.
  task automatic test_back_to_back();
    bit [15:0] s = {8'h33, 8'hAA};
    int vcount = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, s[i], i == 0);
      if (if_c.VALID === 1'b1) vcount++;
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obsv(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL b2b dut%0d bit%0d got %h want %h", k, i, obsv(k), expv(k));
        end
      end
      if (i == 7 || i == 15) begin
        n_vec++;
        if (if_c.VALID !== 1'b1 || if_c.D !== ((i == 7) ? 8'hAA : 8'h33)) begin
          n_fail++;
          $display("FAIL b2b_byte at %0d got V=%b D=%h", i, if_c.VALID, if_c.D);
        end
      end
    end
    n_vec++;
    if (vcount != 2 || if_c.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_count got %0d busy %b want 2 1", vcount, if_c.BUSY);
    end
  endtask

  task automatic test_random(int cycles);
    for (int i = 0; i < cycles; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0,
           1'($urandom), $urandom_range(0, 10) == 0);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (obsv(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d got %h want %h", k, i, obsv(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    cr = 1'b1; en = 1'b0; sin = 1'b0; sync = 1'b0;
    test_reset();
    test_frame(-1, 0);
    test_frame(3, 3);
    test_abort();
    test_mid_reset();
    test_back_to_back();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
